button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 30000000, meaning the cycles an input level must stay stable before it is accepted.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 100000000, meaning the cycles a press must last before a hold event fires.
REQ-003 The block SHALL have parameter CNT_W, default 27, meaning the timer width; it must hold max(SETTLE_CYCLES, HOLD_CYCLES).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port button_in, input, 1 bit: raw, asynchronous, bouncing button level, active-high.
REQ-007 The block SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-008 The block SHALL have port btn_press, output, 1 bit: one-cycle pulse on an accepted press.
REQ-009 The block SHALL have port btn_release, output, 1 bit: one-cycle pulse on an accepted release.
REQ-010 The block SHALL have port btn_hold, output, 1 bit: one-cycle pulse once per press after HOLD_CYCLES.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in WAIT_HIGH or WAIT_LOW.

Function
REQ-012 The block SHALL pass button_in through a 2-flop synchronizer; only the second flop output (sync_in) drives logic.
REQ-013 The block SHALL implement FSM states IDLE_LOW, WAIT_HIGH, PRESSED and WAIT_LOW.
REQ-014 In IDLE_LOW with sync_in=1, the block SHALL go to WAIT_HIGH and clear the timer to 0 on the same edge.
REQ-015 In WAIT_HIGH, the timer SHALL increment by 1 per cycle; done SHALL be combinational, high when timer == SETTLE_CYCLES.
REQ-016 In WAIT_HIGH with sync_in=0 before done, the block SHALL return to IDLE_LOW with no pulse (bounce rejected).
REQ-017 In WAIT_HIGH with done and sync_in=1, the block SHALL go to PRESSED, set btn_level=1, pulse btn_press for 1 cycle, and clear the timer.
REQ-018 In WAIT_HIGH, sync_in=0 SHALL take priority over done on the same edge (go to IDLE_LOW).
REQ-019 In PRESSED, the timer SHALL count to HOLD_CYCLES, then pulse btn_hold once and saturate; it SHALL NOT re-fire in the same press.
REQ-020 In PRESSED with sync_in=0, the block SHALL go to WAIT_LOW and clear the timer; if the hold match coincides, btn_hold SHALL still pulse.
REQ-021 WAIT_LOW SHALL mirror WAIT_HIGH: sync_in=1 before done returns to PRESSED with no pulse and the hold event not re-armed.
REQ-022 In WAIT_LOW with done and sync_in=0, the block SHALL go to IDLE_LOW, set btn_level=0, and pulse btn_release.
REQ-023 Latency: btn_press SHALL be high in the cycle after the (SETTLE_CYCLES+4)th rising edge counted from the first edge that samples button_in high, given button_in stable throughout.
REQ-024 btn_press, btn_release and btn_hold SHALL be registered, mutually exclusive, and never high for 2 consecutive cycles.
REQ-025 The timer SHALL never wrap; it saturates at its compare value.

Reset
REQ-026 On reset: synchronizer flops=0, state=IDLE_LOW, timer=0, hold-fired flag=0; btn_level, btn_press, btn_release, btn_hold, busy=0.
REQ-027 Reset asserted mid-press or mid-wait SHALL abort with no pulse; after release, a held-high input SHALL go through a full settle before btn_press.

Structure
REQ-028 FSM state encodings SHALL live in shared package debounce_pkg.
REQ-029 The timer SHALL be sub-module settle_timer (clock, reset, clear, enable, limit, count, done), instanced once.

Verification
REQ-030 With SETTLE_CYCLES=8, button_in rises clean -> btn_press high exactly 1 cycle, after the 12th edge; btn_level=1 from then.
REQ-031 With SETTLE_CYCLES=8, a 5-cycle high glitch -> no pulse, btn_level stays 0, busy high then low.
REQ-032 With SETTLE_CYCLES=8 and HOLD_CYCLES=20, hold for 40 cycles -> exactly 1 btn_hold pulse, 20 cycles after btn_press, then 1 btn_release 12 cycles after the fall.
REQ-033 A release bounce (3 cycles low, then high) -> no btn_release, no second btn_hold, btn_level stays 1.
REQ-034 Reset asserted in WAIT_HIGH at timer=5 -> all outputs 0 asynchronously; after reset, input still high -> btn_press 12 edges after the first post-reset edge.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer: FSM state encodings and
// small helpers that classify a state.
package debounce_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE_LOW  = 2'd0;
    localparam state_t WAIT_HIGH = 2'd1;
    localparam state_t PRESSED   = 2'd2;
    localparam state_t WAIT_LOW  = 2'd3;

    // A state is "waiting" while a level change is being qualified.
    function automatic logic is_waiting(input state_t st);
        return (st == WAIT_HIGH) || (st == WAIT_LOW);
    endfunction

    // The debounced level is high from the accepted press until the accepted release.
    function automatic logic is_level_high(input state_t st);
        return (st == PRESSED) || (st == WAIT_LOW);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Saturating up-counter used for both settle qualification and hold timing.
// done is combinational so the FSM can act on the same edge the limit is seen.
module settle_timer #(
    parameter int CNT_W = 27
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_r;

    // Count register: clear wins, then increment until the limit is reached.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != limit)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign done  = (count_r == limit);

endmodule

// File: rtl/button_debouncer.sv
// Debouncer for a raw push-button: synchronizes the input, qualifies each level
// change for SETTLE_CYCLES, and emits press/release/hold pulses.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int SETTLE_CYCLES = 30000000,
    parameter int HOLD_CYCLES   = 100000000,
    parameter int CNT_W         = 27
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_hold,
    output logic busy
);

    localparam logic [CNT_W-1:0] SETTLE_LIMIT = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LIMIT   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

    logic             sync1_r;
    logic             sync_in_r;
    state_t           state_r;
    state_t           next_state_s;
    logic             hold_fired_r;
    logic             press_s;
    logic             release_s;
    logic             hold_s;
    logic             clear_s;
    logic             enable_s;
    logic [CNT_W-1:0] limit_s;
    logic [CNT_W-1:0] count_s;
    logic             done_s;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r   <= 1'b0;
            sync_in_r <= 1'b0;
        end else begin
            sync1_r   <= button_in;
            sync_in_r <= sync1_r;
        end
    end

    // Next-state and event decode; a falling input beats the settle match.
    always_comb begin
        next_state_s = state_r;
        press_s      = 1'b0;
        release_s    = 1'b0;
        hold_s       = 1'b0;
        case (state_r)
            IDLE_LOW: begin
                if (sync_in_r) begin
                    next_state_s = WAIT_HIGH;
                end else begin
                    next_state_s = IDLE_LOW;
                end
            end
            WAIT_HIGH: begin
                if (!sync_in_r) begin
                    next_state_s = IDLE_LOW;
                end else if (done_s) begin
                    next_state_s = PRESSED;
                    press_s      = 1'b1;
                end else begin
                    next_state_s = WAIT_HIGH;
                end
            end
            PRESSED: begin
                // Hold fires on the edge the timer reaches HOLD_CYCLES, even if the press ends there.
                hold_s = !hold_fired_r && (count_s == HOLD_LAST);
                if (!sync_in_r) begin
                    next_state_s = WAIT_LOW;
                end else begin
                    next_state_s = PRESSED;
                end
            end
            WAIT_LOW: begin
                if (sync_in_r) begin
                    next_state_s = PRESSED;
                end else if (done_s) begin
                    next_state_s = IDLE_LOW;
                    release_s    = 1'b1;
                end else begin
                    next_state_s = WAIT_LOW;
                end
            end
            default: begin
                next_state_s = IDLE_LOW;
            end
        endcase
    end

    // Restart timing on every state change; the timer idles at zero in IDLE_LOW.
    assign clear_s  = (next_state_s != state_r) || (state_r == IDLE_LOW);
    assign enable_s = !clear_s;
    assign limit_s  = (state_r == PRESSED) ? HOLD_LIMIT : SETTLE_LIMIT;

    settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear_s),
        .enable (enable_s),
        .limit  (limit_s),
        .count  (count_s),
        .done   (done_s)
    );

    // State, hold-once flag and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE_LOW;
            hold_fired_r <= 1'b0;
            btn_level    <= 1'b0;
            btn_press    <= 1'b0;
            btn_release  <= 1'b0;
            btn_hold     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            if (press_s) begin
                hold_fired_r <= 1'b0;
            end else if (hold_s) begin
                hold_fired_r <= 1'b1;
            end else begin
                hold_fired_r <= hold_fired_r;
            end
            btn_level    <= is_level_high(next_state_s);
            btn_press    <= press_s;
            btn_release  <= release_s;
            btn_hold     <= hold_s;
            busy         <= is_waiting(next_state_s);
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bouncing input,
// compared every cycle with a behavioural "run-length" model of the debouncer.
module tb_button_debouncer;

    localparam int S = 8;
    localparam int H = 20;

    logic clock;
    logic reset;
    logic button_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_hold;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic q1_m, q2_m;
    logic m_level, m_press, m_rel, m_hold, m_hold_done;
    int   m_run, m_edge, m_steady;

    // observed DUT events since the last mark
    int edge_n, press_cnt, rel_cnt, hold_cnt, press_edge, rel_edge, hold_edge, busy_seen;

    button_debouncer #(
        .SETTLE_CYCLES (S),
        .HOLD_CYCLES   (H),
        .CNT_W         (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .button_in   (button_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_hold    (btn_hold),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q1_m = 1'b0; q2_m = 1'b0;
        m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_hold = 1'b0; m_hold_done = 1'b0;
        m_run = 0; m_edge = 0; m_steady = 0;
    endtask

    task automatic mark();
        edge_n = 0; press_cnt = 0; rel_cnt = 0; hold_cnt = 0;
        press_edge = -1; rel_edge = -1; hold_edge = -1; busy_seen = 0;
    endtask

    // A new level is accepted once the synchronized input has disagreed with the
    // accepted level for S+2 consecutive edges; hold fires H edges into a steady press.
    task automatic model_step(input logic v);
        m_edge++;
        m_press = 1'b0; m_rel = 1'b0; m_hold = 1'b0;
        if (m_level && m_run == 0 && !m_hold_done && (m_edge - m_steady == H)) begin
            m_hold = 1'b1;
            m_hold_done = 1'b1;
        end
        if (v != m_level) begin
            m_run++;
            if (m_run == S + 2) begin
                m_level = v;
                m_run = 0;
                m_steady = m_edge;
                if (v) begin
                    m_press = 1'b1;
                    m_hold_done = 1'b0;
                end else begin
                    m_rel = 1'b1;
                end
            end
        end else begin
            if (m_run != 0) m_steady = m_edge;
            m_run = 0;
        end
    endtask

    // Drive one input value at the falling edge, clock it, then compare at the next falling edge.
    task automatic run_cycle(input logic x);
        logic v;
        button_in = x;
        v = q2_m; q2_m = q1_m; q1_m = x;
        model_step(v);
        @(posedge clock);
        edge_n++;
        @(negedge clock);
        check_eq("level",   32'(btn_level),   32'(m_level));
        check_eq("press",   32'(btn_press),   32'(m_press));
        check_eq("release", 32'(btn_release), 32'(m_rel));
        check_eq("hold",    32'(btn_hold),    32'(m_hold));
        check_eq("busy",    32'(busy),        32'(m_run != 0));
        if (btn_press)   begin press_cnt++; press_edge = edge_n; end
        if (btn_release) begin rel_cnt++;   rel_edge   = edge_n; end
        if (btn_hold)    begin hold_cnt++;  hold_edge  = edge_n; end
        if (busy) busy_seen = 1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_level"},   32'(btn_level),   32'd0);
        check_eq({tag, "_press"},   32'(btn_press),   32'd0);
        check_eq({tag, "_release"}, 32'(btn_release), 32'd0);
        check_eq({tag, "_hold"},    32'(btn_hold),    32'd0);
        check_eq({tag, "_busy"},    32'(busy),        32'd0);
    endtask

    initial begin
        reset = 1'b1;
        button_in = 1'b0;
        model_clear();
        mark();
        repeat (3) @(negedge clock);
        check_all_zero("rst");
        reset = 1'b0;

        repeat (3) run_cycle(1'b0);

        // clean press held long enough for one hold event
        mark();
        repeat (45) run_cycle(1'b1);
        check_eq("press_edge", press_edge, 32'd12);
        check_eq("press_cnt",  press_cnt,  32'd1);
        check_eq("hold_edge",  hold_edge,  32'd32);
        check_eq("hold_cnt",   hold_cnt,   32'd1);
        check_eq("level_held", 32'(btn_level), 32'd1);

        // short release bounce is rejected
        mark();
        repeat (3) run_cycle(1'b0);
        repeat (30) run_cycle(1'b1);
        check_eq("bounce_rel",   rel_cnt,  32'd0);
        check_eq("bounce_hold",  hold_cnt, 32'd0);
        check_eq("bounce_level", 32'(btn_level), 32'd1);

        // clean release
        mark();
        repeat (20) run_cycle(1'b0);
        check_eq("rel_edge", rel_edge, 32'd12);
        check_eq("rel_cnt",  rel_cnt,  32'd1);

        // 5-cycle glitch
        mark();
        repeat (5) run_cycle(1'b1);
        repeat (20) run_cycle(1'b0);
        check_eq("glitch_press", press_cnt, 32'd0);
        check_eq("glitch_busy",  busy_seen, 32'd1);
        check_eq("glitch_level", 32'(btn_level), 32'd0);
        check_eq("glitch_idle",  32'(busy), 32'd0);

        // release begins exactly when the hold match is reached
        mark();
        repeat (29) run_cycle(1'b1);
        repeat (20) run_cycle(1'b0);
        check_eq("coinc_hold_edge", hold_edge, 32'd32);
        check_eq("coinc_hold_cnt",  hold_cnt,  32'd1);
        check_eq("coinc_rel_edge",  rel_edge,  32'd41);

        // asynchronous reset while waiting at timer=5
        mark();
        repeat (8) run_cycle(1'b1);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("arst");
        repeat (2) @(negedge clock);
        check_all_zero("arst_hold");
        reset = 1'b0;
        model_clear();
        mark();
        repeat (15) run_cycle(1'b1);
        check_eq("post_rst_press_edge", press_edge, 32'd12);
        check_eq("post_rst_press_cnt",  press_cnt,  32'd1);

        // random bouncing input
        for (int seg = 0; seg < 250; seg++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) len = $urandom_range(8, 40);
            else                           len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) run_cycle(lvl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
